alu_exec_stage: RTL

Registered execute stage that consumes the 3-bit ALU control code produced by the ALU decoder and performs the selected operation on two operands. It sits between decode and writeback/branch-resolve. Results leave through a valid/ready handshake with a 2-entry skid buffer, so downstream backpressure never drops or duplicates an operation. A wrapping completion counter supports UVM scoreboarding.

---
 rtl/alu_exec_stage.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_stage
// Purpose  : Registered ALU execute stage. Computes ADD/SUB/AND/OR/SLT on two
//            operands and hands results downstream through a valid/ready
//            interface backed by an output register plus one skid register.
//            Counts completed output handshakes with a wrapping counter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0]       C_OP_ADD  = 3'b000;
  localparam logic [2:0]       C_OP_SUB  = 3'b001;
  localparam logic [2:0]       C_OP_AND  = 3'b010;
  localparam logic [2:0]       C_OP_OR   = 3'b011;
  localparam logic [2:0]       C_OP_SLT  = 3'b100;
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Occupancy of the output register + skid register pair.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic             r_out_zero;
  logic             r_out_illegal;
  logic [WIDTH-1:0] r_skid_result;
  logic             r_skid_zero;
  logic             r_skid_illegal;
  logic [CNT_W-1:0] r_count;

  logic [WIDTH-1:0] w_res;
  logic             w_zero;
  logic             w_illegal;
  logic             w_lt;
  logic             w_accept;
  logic             w_deliver;
  logic             w_load_out;
  logic             w_load_out_skid;
  logic             w_load_skid;

  assign w_accept  = in_valid && r_in_ready;
  assign w_deliver = r_out_valid && out_ready;
  assign w_lt      = ($signed(src_a) < $signed(src_b));

  // ALU datapath: illegal codes yield a zero result flagged as illegal.
  always_comb begin
    w_res     = '0;
    w_illegal = 1'b0;
    case (alu_ctrl)
      C_OP_ADD: w_res = src_a + src_b;
      C_OP_SUB: w_res = src_a - src_b;
      C_OP_AND: w_res = src_a & src_b;
      C_OP_OR:  w_res = src_a | src_b;
      C_OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_lt};
      default:  w_illegal = 1'b1;
    endcase
    w_zero = (w_res == '0);
  end

  // Next occupancy and which buffer register captures what this cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_load_out      = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_load_out  = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_deliver) begin
          w_load_out = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = ST_FULL;
          w_load_skid = 1'b1;
        end else if (w_deliver) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so no new operation can arrive.
        if (w_deliver) begin
          w_state_nxt     = ST_ONE;
          w_load_out_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Occupancy register; handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      r_in_ready  <= (w_state_nxt != ST_FULL);
    end
  end

  // Output and skid data registers; held stable unless explicitly loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_result   <= '0;
      r_out_zero     <= 1'b0;
      r_out_illegal  <= 1'b0;
      r_skid_result  <= '0;
      r_skid_zero    <= 1'b0;
      r_skid_illegal <= 1'b0;
    end else begin
      if (w_load_out) begin
        r_out_result  <= w_res;
        r_out_zero    <= w_zero;
        r_out_illegal <= w_illegal;
      end else if (w_load_out_skid) begin
        r_out_result  <= r_skid_result;
        r_out_zero    <= r_skid_zero;
        r_out_illegal <= r_skid_illegal;
      end
      if (w_load_skid) begin
        r_skid_result  <= w_res;
        r_skid_zero    <= w_zero;
        r_skid_illegal <= w_illegal;
      end
    end
  end

  // Completed-operation counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_deliver) begin
      r_count <= r_count + C_CNT_ONE;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_out_result;
  assign zero      = r_out_zero;
  assign illegal   = r_out_illegal;
  assign op_count  = r_count;

endmodule
`default_nettype wire
